// File: rtl/bus_pkg.sv
// Shared definitions for the CPU bus initiator: default widths, FSM encoding and
// the data value returned on an aborted access.
package bus_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;
  localparam logic [7:0] BUS_ERR_DATA = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;
endpackage

// File: rtl/bus_timeout_counter.sv
// Cycle counter for the bus watchdog: counts enabled cycles since the last clear and
// flags expiry on the TIMEOUT_CYCLES-th counted cycle.
module bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CNT_W-1:0] r_cnt;

  // Saturates at the expiry value so a stuck state keeps reporting expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       r_cnt <= '0;
    else if (i_clear)              r_cnt <= '0;
    else if (i_en && !o_expired)   r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_expired = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/bus_initiator.sv
// Single-outstanding initiator for the 16-bit address / 8-bit data CPU bus.
// Define BUS_TIMEOUT_EN to add the ACCESS/RECOVER watchdog (rsp_error, BUS_ERR_DATA).
module bus_initiator
  import bus_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              busy,
  output logic [ADDR_W-1:0] bus_address_out,
  output logic [DATA_W-1:0] bus_data_out,
  input  logic [DATA_W-1:0] bus_data_in,
  output logic              bus_read,
  output logic              bus_write,
  input  logic              bus_wait
);
  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rd;
  logic              r_wr;
  logic              r_rsp_valid;
  logic              r_rsp_error;
  logic              w_done;
  logic              w_expired;

  assign w_done = (r_state == ST_ACCESS) && !bus_wait;

`ifdef BUS_TIMEOUT_EN
  logic w_cnt_clear;
  // Held clear in IDLE and on the ACCESS->RECOVER edge, so each phase counts from zero.
  assign w_cnt_clear = (r_state == ST_IDLE) || (r_state == ST_ACCESS && (w_done || w_expired));

  bus_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_cnt_clear),
    .i_en      (r_state != ST_IDLE),
    .o_expired (w_expired)
  );
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
  assign w_expired    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: if (req_valid) begin
          r_addr  <= req_addr;
          r_wdata <= req_wdata;
          r_rd    <= !req_write;
          r_wr    <= req_write;
          r_state <= ST_ACCESS;
        end
        ST_ACCESS: if (!bus_wait) begin
          if (r_rd) r_rdata <= bus_data_in;
          r_rd        <= 1'b0;
          r_wr        <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_rsp_error <= 1'b0;
          r_state     <= ST_RECOVER;
        end else if (w_expired) begin
          r_rdata     <= DATA_W'(BUS_ERR_DATA);
          r_rd        <= 1'b0;
          r_wr        <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_rsp_error <= 1'b1;
          r_state     <= ST_RECOVER;
        end
        // Wait for the responder to drop its completion before the next strobe.
        ST_RECOVER: if (bus_wait || w_expired) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready       = (r_state == ST_IDLE);
  assign busy            = (r_state != ST_IDLE);
  assign bus_address_out = r_addr;
  assign bus_data_out    = r_wdata;
  assign bus_read        = r_rd;
  assign bus_write       = r_wr;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_rdata       = r_rdata;
  assign rsp_error       = r_rsp_error;
endmodule

// File: tb/tb_bus_initiator.sv
// Bench for bus_initiator: behavioural responder with programmable stall, protocol
// monitor, and a memory-map reference model for expected response data.
module tb_bus_initiator;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_error, busy, bus_read, bus_write;
  logic [7:0]  rsp_rdata, bus_data_out;
  logic [15:0] bus_address_out;
  logic [7:0]  bus_data_in = '0;
  logic        bus_wait = 1'b1;

  always #5 clk = ~clk;

  bus_initiator #(.ADDR_W(16), .DATA_W(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .busy(busy),
    .bus_address_out(bus_address_out), .bus_data_out(bus_data_out), .bus_data_in(bus_data_in),
    .bus_read(bus_read), .bus_write(bus_write), .bus_wait(bus_wait)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] dflt(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Responder: completes `stall` cycles after first seeing a strobe, releases on strobe low.
  logic [7:0] bmem [int];
  int stall = 0, rcnt = 0;
  bit never = 0;
  always @(posedge clk) begin
    if (!(bus_read || bus_write)) begin
      bus_wait <= 1'b1;
      rcnt     <= 0;
    end else if (bus_wait && !never) begin
      if (rcnt >= stall) begin
        bus_wait <= 1'b0;
        if (bus_read)
          bus_data_in <= bmem.exists(int'(bus_address_out)) ? bmem[int'(bus_address_out)]
                                                            : dflt(bus_address_out);
        else
          bmem[int'(bus_address_out)] = bus_data_out;
      end else rcnt <= rcnt + 1;
    end
  end

  // Protocol monitor
  int   rsp_cnt = 0, stb_cycles = 0, last_stb = 0;
  bit   prev_stb = 0, prev_rsp = 0, gap_ok = 1;
  logic [15:0] p_addr;
  logic [7:0]  p_data;
  logic [1:0]  p_kind;
  always @(negedge clk) begin
    if (rst) begin
      prev_stb = 0; prev_rsp = 0; gap_ok = 1;
    end else begin
      if (bus_read || bus_write) begin
        chk("one_strobe", {31'd0, bus_read & bus_write}, 0);
        if (prev_stb) begin
          chk("hold_addr", {16'd0, bus_address_out}, {16'd0, p_addr});
          chk("hold_data", {24'd0, bus_data_out}, {24'd0, p_data});
          chk("hold_kind", {30'd0, bus_read, bus_write}, {30'd0, p_kind});
        end else begin
          chk("recover_gap", {31'd0, gap_ok}, 1);
          stb_cycles = 0;
        end
        stb_cycles++;
      end else if (prev_stb) begin
        gap_ok   = bus_wait;
        last_stb = stb_cycles;
      end else if (bus_wait) gap_ok = 1;
      if (rsp_valid) begin
        rsp_cnt++;
        if (prev_rsp) chk("rsp_pulse", 1, 0);
      end
      prev_stb = bus_read || bus_write;
      prev_rsp = rsp_valid;
      p_addr = bus_address_out; p_data = bus_data_out; p_kind = {bus_read, bus_write};
    end
  end

  // Reference model state
  logic [7:0] mmem [int];
  logic [7:0] last_rd = 8'h00;

  task automatic issue(input bit w, input logic [15:0] a, input logic [7:0] d, input bit hold);
    int n = 0;
    @(negedge clk);
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    chk("accept", {31'd0, req_ready}, 1);
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input logic [7:0] ed, input bit ee,
                            input int elat, input int estb);
    int n = 1;
    @(negedge clk);
    while (!rsp_valid && n < 80) begin @(negedge clk); n++; end
    chk({tag, "_seen"}, {31'd0, rsp_valid}, 1);
    chk({tag, "_lat"}, n, elat);
    chk({tag, "_rdata"}, {24'd0, rsp_rdata}, {24'd0, ed});
    chk({tag, "_err"}, {31'd0, rsp_error}, {31'd0, ee});
    #1 chk({tag, "_stb_cycles"}, last_stb, estb);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!req_ready && n < 60) begin @(negedge clk); n++; end
    chk({tag, "_idle"}, {31'd0, req_ready}, 1);
  endtask

  function automatic logic [7:0] model_read(input logic [15:0] a);
    return mmem.exists(int'(a)) ? mmem[int'(a)] : dflt(a);
  endfunction

  task automatic do_acc(input string tag, input bit w, input logic [15:0] a,
                        input logic [7:0] d, input int st);
    logic [7:0] ed;
    int c0;
    stall = st; c0 = rsp_cnt;
    if (w) begin mmem[int'(a)] = d; ed = last_rd; end
    else begin ed = model_read(a); last_rd = ed; end
    issue(w, a, d, 1'b0);
    expect_rsp(tag, ed, 1'b0, st + 3, st + 2);
    wait_idle(tag);
    repeat (2) @(negedge clk);
    chk({tag, "_nrsp"}, rsp_cnt - c0, 1);
  endtask

  initial begin
    int c0;
    bmem[0] = 8'h3E; bmem[1] = 8'h55;
    mmem[0] = 8'h3E; mmem[1] = 8'h55;
    rst = 1'b1;
    #12;
    chk("rst_read",  {31'd0, bus_read}, 0);
    chk("rst_write", {31'd0, bus_write}, 0);
    chk("rst_addr",  {16'd0, bus_address_out}, 0);
    chk("rst_data",  {24'd0, bus_data_out}, 0);
    chk("rst_rsp",   {29'd0, rsp_valid, rsp_error, |rsp_rdata}, 0);
    chk("rst_ready", {30'd0, req_ready, busy}, 32'h2);
    @(negedge clk); rst = 1'b0;

    do_acc("rd_0001", 1'b0, 16'h0001, 8'h00, 0);
    do_acc("wr_aabb", 1'b1, 16'hAABB, 8'hA5, 0);
    do_acc("rd_aabb", 1'b0, 16'hAABB, 8'h00, 1);
    do_acc("stall5",  1'b0, 16'h1357, 8'h00, 5);
    do_acc("rd_ffff", 1'b0, 16'hFFFF, 8'h00, 0);

    // Back-to-back reads with req_valid held high across the first access
    stall = 0; c0 = rsp_cnt;
    issue(1'b0, 16'h0000, 8'h00, 1'b1);
    req_addr = 16'h0001;
    expect_rsp("b2b_0", 8'h3E, 1'b0, 3, 2);
    chk("b2b_busy_ready", {31'd0, req_ready}, 0);
    issue(1'b0, 16'h0001, 8'h00, 1'b0);
    expect_rsp("b2b_1", 8'h55, 1'b0, 3, 2);
    last_rd = 8'h55;
    wait_idle("b2b");
    repeat (2) @(negedge clk);
    chk("b2b_nrsp", rsp_cnt - c0, 2);

    // Reset in the middle of a stalled access
    stall = 20;
    issue(1'b0, 16'h1234, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    chk("pre_rst_stb", {31'd0, bus_read}, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_stb", {30'd0, bus_read, bus_write}, 0);
    chk("rst_mid_busy", {31'd0, busy}, 0);
    last_rd = 8'h00;
    @(negedge clk); rst = 1'b0; c0 = rsp_cnt;
    repeat (6) @(negedge clk);
    chk("rst_mid_norsp", rsp_cnt - c0, 0);
    chk("rst_mid_ready", {31'd0, req_ready}, 1);

    // Randomized accesses against the model
    for (int i = 0; i < 24; i++) begin
      bit w;
      logic [15:0] a;
      logic [7:0] d;
      w = 1'($urandom_range(1, 0));
      a = ($urandom_range(3, 0) == 0) ? 16'hAABB : 16'($urandom);
      d = 8'($urandom);
      do_acc($sformatf("rnd%0d", i), w, a, d, int'($urandom_range(3, 0)));
    end

`ifdef BUS_TIMEOUT_EN
    never = 1;
    c0 = rsp_cnt;
    issue(1'b0, 16'h4242, 8'h00, 1'b0);
    expect_rsp("timeout", 8'hFF, 1'b1, TO + 1, TO);
    wait_idle("timeout");
    repeat (2) @(negedge clk);
    chk("timeout_nrsp", rsp_cnt - c0, 1);
    never = 0;
    last_rd = 8'hFF;
    do_acc("post_to", 1'b1, 16'h0042, 8'h24, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
